ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction-fetch stage of the miniRV core; directly upstream of decode and the immediate extender.
- Owns the PC register and runs a req/gnt/rvalid handshake to instruction memory.
- Presents inst/inst_pc to decode with valid/ready; decode slices inst[31:7] into the immediate extender.
- Accepts control-flow redirects from execute and computes branch/JAL/JALR targets from the extended immediate.

Parameters:
- RESET_PC, 32'h0000_0000, PC of first fetch after reset.

Ports:
- cpu_clk  in  1  clock; all state updates on rising edge.
- cpu_rst_n  in  1  reset, synchronous, active-low.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; stable while imem_req=1 and imem_gnt=0.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; arrives ≥1 cycle after gnt, one per gnt.
- imem_rdata  in  32  instruction word, valid with imem_rvalid.
- inst_valid  out  1  inst/inst_pc valid to decode.
- inst_ready  in  1  decode accepts.
- inst  out  32  fetched instruction.
- inst_pc  out  32  PC of inst.
- redir_valid  in  1  execute redirects the fetch stream.
- redir_op  in  2  target kind; codes NPC_BR, NPC_JAL, NPC_JALR from param.v.
- redir_pc  in  32  PC of the redirecting instruction.
- redir_rs1  in  32  rs1 value (JALR only).
- redir_imm  in  32  sign-extended immediate from the extender.
- misalign_exc  out  1  target misaligned (tied 0 when the optional feature is absent).

Behaviour:
- Reset (cpu_rst_n=0 at a clock edge):
  - pc←RESET_PC; state←S_IDLE; kill←0; pend←0.
  - imem_req=0, inst_valid=0, inst=0, inst_pc=0, misalign_exc=0.
- FSM states: S_IDLE, S_REQ, S_WAIT, S_OUT, S_EXC.
  - S_IDLE→S_REQ unconditionally; first imem_req is asserted exactly 1 cycle after reset release.
  - S_REQ: imem_req=1, imem_addr=pc. On imem_gnt→S_WAIT.
  - S_WAIT: on imem_rvalid:
    - kill=1: discard the word, clear kill, →S_REQ.
    - otherwise: capture inst←imem_rdata, inst_pc←pc, →S_OUT.
  - S_OUT: inst_valid = (state==S_OUT) & ~redir_valid. On inst_valid&inst_ready: pc←inst_pc+4, →S_REQ. No fetch is issued while in S_OUT (one instruction in flight).
- Fetch latency: gnt at cycle N, rvalid at N+k gives inst_valid at N+k+1 and the next imem_req at N+k+2 at the earliest.
- Redirect target, 32-bit modulo arithmetic, carries dropped:
  - NPC_BR / NPC_JAL: redir_pc+redir_imm.
  - NPC_JALR: (redir_rs1+redir_imm)&~32'h1.
  - redir_op=2'b11: treat as NPC_BR.
- Redirect in each state (redirect always wins):
  - S_IDLE / S_REQ without gnt: pc←target; imem_addr is not changed mid-request. The captured target is held in pend and becomes imem_addr when S_REQ is (re)entered. In S_REQ the target is held in pend and kill←1 so the in-flight word is dropped; pc←target once that word is discarded.
  - S_REQ with gnt in the same cycle: kill←1, pc←target, →S_WAIT.
  - S_WAIT: kill←1, pc←target. The response is discarded on rvalid, then →S_REQ with the new pc. If rvalid arrives in the same cycle, discard it and →S_REQ.
  - S_OUT: inst_valid is masked low, the held instruction is dropped, pc←target, →S_REQ. A simultaneous inst_ready has no effect.
- Back-to-back redirects: the last one wins; the kill flag saturates at 1 (at most one outstanding response).
- Reset mid-transaction: state returns to S_IDLE. A late rvalid after reset is ignored because the state is not S_WAIT.

Optional Feature:
- Macro IFU_MISALIGN_CHK_EN.
  - Defined: if target[1:0]!=0 on redirect, go to S_EXC: imem_req=0, inst_valid=0, misalign_exc=1. Hold until the next redirect with an aligned target, which clears misalign_exc and →S_REQ. An in-flight response is still discarded via kill.
  - Undefined: misalign_exc tied 0; target[1:0] forced to 2'b00; S_EXC is not synthesised.

Decomposition:
- param.v holds NPC_BR=2'd0, NPC_JAL=2'd1, NPC_JALR=2'd2, the FSM state encodings and the RESET_PC default.
- One combinational sub-module, ifu_npc (redir_op, redir_pc, redir_rs1, redir_imm → target), reused by the single-cycle NPC path.

Test Plan:
- Reset then gnt immediate, rvalid 1 cycle later, rdata=32'h00500093, inst_ready=1 → imem_addr 0x0, then 0x4; inst_valid pulses with inst_pc=0x0.
- inst_ready held 0 for 5 cycles → inst/inst_pc stable, imem_req=0 throughout; release → next addr=inst_pc+4.
- In S_WAIT, redir_valid NPC_BR, redir_pc=0x100, redir_imm=32'hFFFF_FFF0 → response dropped, next imem_addr=0xF0, no inst_valid for the old word.
- NPC_JALR, rs1=0x2003, imm=0x4 → imem_addr=0x2006; with IFU_MISALIGN_CHK_EN, misalign_exc=1 and imem_req=0 until an aligned redirect.
- redir_valid in S_OUT coinciding with inst_ready=1 → inst_valid=0 that cycle, next imem_addr=target.
- Assert cpu_rst_n=0 in S_WAIT, deliver rvalid during reset → all outputs 0, first post-reset imem_addr=RESET_PC.

Source files
------------

// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch shared definitions: next-PC op codes, FSM states, reset PC.
// Included by ifu_npc and ifu_fetch.
package ifu_fetch_pkg;

  localparam logic [1:0] NPC_BR   = 2'd0;
  localparam logic [1:0] NPC_JAL  = 2'd1;
  localparam logic [1:0] NPC_JALR = 2'd2;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_EXC
  } state_e;

endpackage

// File: rtl/ifu_npc.sv
// Next-PC target adder for branch / JAL / JALR redirects.
// Pure combinational; op 2'b11 falls through to the branch form.
module ifu_npc
  import ifu_fetch_pkg::*;
(
  input  logic [1:0]  redir_op,
  input  logic [31:0] redir_pc,
  input  logic [31:0] redir_rs1,
  input  logic [31:0] redir_imm,
  output logic [31:0] target
);

  logic [31:0] jalr_sum;

  assign jalr_sum = redir_rs1 + redir_imm;

  always_comb begin
    target = redir_pc + redir_imm;
    if (redir_op == NPC_JALR) begin
      target = {jalr_sum[31:1], 1'b0};
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// miniRV fetch stage: PC, imem req/gnt/rvalid, one instruction in flight.
// Optional misaligned-target trap: define IFU_MISALIGN_CHK_EN.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redir_valid,
  input  logic [1:0]  redir_op,
  input  logic [31:0] redir_pc,
  input  logic [31:0] redir_rs1,
  input  logic [31:0] redir_imm,
  output logic        misalign_exc
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ipc_q, ipc_d;
  logic        pend_v_q, pend_v_d;
  logic        kill_q, kill_d;
  logic        exc_q, exc_d;
  logic [31:0] npc_raw, tgt;

  ifu_npc u_npc (
    .redir_op  (redir_op),
    .redir_pc  (redir_pc),
    .redir_rs1 (redir_rs1),
    .redir_imm (redir_imm),
    .target    (npc_raw)
  );

`ifdef IFU_MISALIGN_CHK_EN
  logic tgt_bad;
  logic owed;

  assign tgt     = npc_raw;
  assign tgt_bad = |npc_raw[1:0];
  // a response is still due from imem after this edge
  assign owed = (state_q == S_REQ && imem_gnt)
              || (!imem_rvalid && (state_q == S_WAIT
              || (state_q == S_EXC && kill_q)));
`else
  assign tgt = {npc_raw[31:2], 2'b00};
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    kill_d   = kill_q;
    inst_d   = inst_q;
    ipc_d    = ipc_q;
    exc_d    = exc_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redir_valid) begin
          pc_d     = tgt;
          pend_v_d = 1'b0;
        end
      end
      S_REQ: begin
        if (imem_gnt) begin
          state_d = S_WAIT;
        end
        if (redir_valid) begin
          kill_d = 1'b1;
          // imem_addr must hold until gnt, so park the target
          if (imem_gnt) begin
            pc_d     = tgt;
            pend_v_d = 1'b0;
          end else begin
            pend_d   = tgt;
            pend_v_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
          kill_d  = 1'b0;
          if (kill_q) begin
            if (pend_v_q) begin
              pc_d = pend_q;
            end
            pend_v_d = 1'b0;
          end else if (!redir_valid) begin
            inst_d  = imem_rdata;
            ipc_d   = pc_q;
            state_d = S_OUT;
          end
        end
        if (redir_valid) begin
          pc_d     = tgt;
          pend_v_d = 1'b0;
          if (!imem_rvalid) begin
            kill_d = 1'b1;
          end
        end
      end
      S_OUT: begin
        if (redir_valid) begin
          pc_d    = tgt;
          state_d = S_REQ;
        end else if (inst_ready) begin
          pc_d    = ipc_q + 32'd4;
          state_d = S_REQ;
        end
      end
`ifdef IFU_MISALIGN_CHK_EN
      S_EXC: begin
        kill_d = kill_q & ~imem_rvalid;
        if (redir_valid) begin
          pc_d    = tgt;
          exc_d   = 1'b0;
          state_d = kill_d ? S_WAIT : S_REQ;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef IFU_MISALIGN_CHK_EN
    if (redir_valid && tgt_bad) begin
      state_d  = S_EXC;
      exc_d    = 1'b1;
      pend_v_d = 1'b0;
      kill_d   = owed;
    end
`endif
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      pend_q   <= RESET_PC;
      pend_v_q <= 1'b0;
      kill_q   <= 1'b0;
      inst_q   <= '0;
      ipc_q    <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      kill_q   <= kill_d;
      inst_q   <= inst_d;
      ipc_q    <= ipc_d;
      exc_q    <= exc_d;
    end
  end

  assign imem_req     = (state_q == S_REQ);
  assign imem_addr    = pc_q;
  assign inst_valid   = (state_q == S_OUT) && !redir_valid;
  assign inst         = inst_q;
  assign inst_pc      = ipc_q;
  assign misalign_exc = exc_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch with a randomized imem responder.
// Build with or without IFU_MISALIGN_CHK_EN to match the RTL.
`timescale 1ns/1ps
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redir_valid;
  logic [1:0]  redir_op;
  logic [31:0] redir_pc;
  logic [31:0] redir_rs1;
  logic [31:0] redir_imm;
  logic        misalign_exc;

  int tests = 0;
  int fails = 0;

  int gnt_pct = 100;
  int lat_min = 1;
  int lat_max = 1;

  logic        busy;
  int          wait_cnt;
  logic [31:0] busy_addr;
  logic [31:0] gnt_q[$];
  logic [31:0] acc_pc_q[$];
  logic [31:0] acc_in_q[$];

  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr = '0;

  ifu_fetch #(.RESET_PC(RST_PC)) dut (
    .cpu_clk      (cpu_clk),
    .cpu_rst_n    (cpu_rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .redir_valid  (redir_valid),
    .redir_op     (redir_op),
    .redir_pc     (redir_pc),
    .redir_rs1    (redir_rs1),
    .redir_imm    (redir_imm),
    .misalign_exc (misalign_exc)
  );

  always #5 cpu_clk = ~cpu_clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
  endfunction

  function automatic logic [31:0] exp_target(
    input logic [1:0] op, input logic [31:0] pc,
    input logic [31:0] rs1, input logic [31:0] imm);
    logic [31:0] t;
    if (op == 2'd2) t = ((rs1 + imm) >> 1) << 1;
    else t = pc + imm;
`ifndef IFU_MISALIGN_CHK_EN
    t = (t >> 2) << 2;
`endif
    return t;
  endfunction

  // instruction memory: grants with probability gnt_pct, answers later
  initial begin
    busy = 1'b0;
    wait_cnt = 0;
    busy_addr = '0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge cpu_clk);
      #1;
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      if (busy) begin
        if (wait_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata = mem_word(busy_addr);
          busy = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
      if (!busy && imem_req === 1'b1
          && int'($urandom_range(99)) < gnt_pct) begin
        imem_gnt = 1'b1;
        busy = 1'b1;
        busy_addr = imem_addr;
        wait_cnt = int'($urandom_range(lat_max, lat_min)) - 1;
        gnt_q.push_back(imem_addr);
      end
    end
  end

  always @(negedge cpu_clk) begin
    if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
      acc_pc_q.push_back(inst_pc);
      acc_in_q.push_back(inst);
    end
    if (prev_hold && imem_req === 1'b1) begin
      tests++;
      if (imem_addr !== prev_addr) begin
        fails++;
        $display("FAIL addr_stable: got %h want %h", imem_addr, prev_addr);
      end
    end
    prev_hold = (cpu_rst_n === 1'b1) && (imem_req === 1'b1)
              && (imem_gnt !== 1'b1);
    prev_addr = imem_addr;
  end

  task automatic clear_logs();
    gnt_q.delete();
    acc_pc_q.delete();
    acc_in_q.delete();
  endtask

  task automatic do_reset();
    @(posedge cpu_clk);
    #1;
    cpu_rst_n = 1'b0;
    redir_valid = 1'b0;
    inst_ready = 1'b0;
    repeat (3) @(posedge cpu_clk);
    #1;
    cpu_rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic wait_gnts(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge cpu_clk);
      if (gnt_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_acc(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge cpu_clk);
      if (acc_pc_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge cpu_clk);
      if (inst_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_redir(input logic [1:0] op, input logic [31:0] pc,
                             input logic [31:0] rs1, input logic [31:0] imm);
    @(posedge cpu_clk);
    #1;
    redir_valid = 1'b1;
    redir_op = op;
    redir_pc = pc;
    redir_rs1 = rs1;
    redir_imm = imm;
    @(posedge cpu_clk);
    #1;
    redir_valid = 1'b0;
  endtask

  task automatic test_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    @(posedge cpu_clk);
    #1;
    cpu_rst_n = 1'b0;
    redir_valid = 1'b0;
    inst_ready = 1'b1;
    repeat (2) @(posedge cpu_clk);
    @(negedge cpu_clk);
    tests++;
    if ({imem_req, inst_valid, misalign_exc, inst, inst_pc} !== '0) begin
      fails++;
      $display("FAIL reset_outs: req=%b v=%b exc=%b inst=%h pc=%h want 0",
               imem_req, inst_valid, misalign_exc, inst, inst_pc);
    end
    @(posedge cpu_clk);
    #1;
    cpu_rst_n = 1'b1;
    clear_logs();
    @(negedge cpu_clk);
    tests++;
    if (imem_req !== 1'b0) begin
      fails++;
      $display("FAIL idle_no_req: got %b want 0", imem_req);
    end
    @(negedge cpu_clk);
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC || imem_gnt !== 1'b1) begin
      fails++;
      $display("FAIL first_req: req=%b addr=%h gnt=%b want 1 %h 1",
               imem_req, imem_addr, imem_gnt, RST_PC);
    end
    @(negedge cpu_clk);
    tests++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
      fails++;
      $display("FAIL wait_quiet: req=%b v=%b want 0 0", imem_req, inst_valid);
    end
    @(negedge cpu_clk);
    tests++;
    if (inst_valid !== 1'b1 || inst !== 32'h0050_0093 || inst_pc !== RST_PC) begin
      fails++;
      $display("FAIL first_inst: v=%b inst=%h pc=%h want 1 00500093 %h",
               inst_valid, inst, inst_pc, RST_PC);
    end
    @(negedge cpu_clk);
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC + 32'd4) begin
      fails++;
      $display("FAIL second_req: req=%b addr=%h want 1 %h",
               imem_req, imem_addr, RST_PC + 32'd4);
    end
    @(posedge cpu_clk);
    #1;
    inst_ready = 1'b0;
  endtask

  task automatic test_stall();
    bit ok;
    logic [31:0] hold_inst, hold_pc;
    do_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    wait_valid(ok);
    tests++;
    if (!ok || inst_pc !== RST_PC || inst !== mem_word(RST_PC)) begin
      fails++;
      $display("FAIL stall_first: ok=%b pc=%h inst=%h want %h %h",
               ok, inst_pc, inst, RST_PC, mem_word(RST_PC));
    end
    hold_inst = inst;
    hold_pc = inst_pc;
    for (int i = 0; i < 5; i++) begin
      @(negedge cpu_clk);
      tests++;
      if (inst_valid !== 1'b1 || imem_req !== 1'b0
          || inst !== hold_inst || inst_pc !== hold_pc) begin
        fails++;
        $display("FAIL stall_hold: v=%b req=%b inst=%h pc=%h want 1 0 %h %h",
                 inst_valid, imem_req, inst, inst_pc, hold_inst, hold_pc);
      end
    end
    @(posedge cpu_clk);
    #1;
    inst_ready = 1'b1;
    @(posedge cpu_clk);
    #1;
    inst_ready = 1'b0;
    wait_gnts(2, ok);
    tests++;
    if (!ok || gnt_q[1] !== hold_pc + 32'd4) begin
      fails++;
      $display("FAIL stall_next: ok=%b addr=%h want %h",
               ok, ok ? gnt_q[1] : 32'h0, hold_pc + 32'd4);
    end
  endtask

  task automatic test_sequential();
    bit done;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      gnt_pct = int'($urandom_range(100, 30));
      lat_min = 1;
      lat_max = int'($urandom_range(4, 1));
      done = 1'b0;
      for (int c = 0; c < 3000 && !done; c++) begin
        @(posedge cpu_clk);
        #1;
        inst_ready = ($urandom_range(2) != 0);
        if (acc_pc_q.size() >= 20) begin
          inst_ready = 1'b0;
          done = 1'b1;
        end
      end
      tests++;
      if (!done) begin
        fails++;
        $display("FAIL seq_timeout: got %0d insts want 20", acc_pc_q.size());
      end else begin
        for (int i = 0; i < 20; i++) begin
          tests++;
          if (acc_pc_q[i] !== RST_PC + 32'(4 * i)
              || acc_in_q[i] !== mem_word(RST_PC + 32'(4 * i))
              || gnt_q[i] !== RST_PC + 32'(4 * i)) begin
            fails++;
            $display("FAIL seq_%0d: pc=%h inst=%h gnt=%h want %h %h",
                     i, acc_pc_q[i], acc_in_q[i], gnt_q[i],
                     RST_PC + 32'(4 * i), mem_word(RST_PC + 32'(4 * i)));
          end
        end
      end
    end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    do_reset();
    gnt_pct = 100; lat_min = 3; lat_max = 3;
    inst_ready = 1'b1;
    wait_gnts(1, ok);
    pulse_redir(2'd0, 32'h0000_0100, 32'h0, 32'hFFFF_FFF0);
    wait_gnts(2, ok);
    tests++;
    if (!ok || gnt_q[1] !== 32'h0000_00F0) begin
      fails++;
      $display("FAIL wait_redir_addr: ok=%b addr=%h want 000000f0",
               ok, ok ? gnt_q[1] : 32'h0);
    end
    wait_acc(1, ok);
    tests++;
    if (!ok || acc_pc_q[0] !== 32'h0000_00F0
        || acc_in_q[0] !== mem_word(32'h0000_00F0)) begin
      fails++;
      $display("FAIL wait_redir_inst: ok=%b pc=%h want 000000f0", ok,
               ok ? acc_pc_q[0] : 32'h0);
    end
    inst_ready = 1'b0;
  endtask

  task automatic test_jalr();
    bit ok;
    do_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 2;
    inst_ready = 1'b0;
    wait_valid(ok);
    pulse_redir(2'd2, 32'h0000_0040, 32'h0000_2003, 32'h0000_0004);
`ifdef IFU_MISALIGN_CHK_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge cpu_clk);
      tests++;
      if (misalign_exc !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
        fails++;
        $display("FAIL jalr_exc: exc=%b req=%b v=%b want 1 0 0",
                 misalign_exc, imem_req, inst_valid);
      end
    end
    pulse_redir(2'd0, 32'h0000_0300, 32'h0, 32'h0000_0010);
    wait_gnts(2, ok);
    tests++;
    if (!ok || gnt_q[1] !== 32'h0000_0310 || misalign_exc !== 1'b0) begin
      fails++;
      $display("FAIL jalr_recover: addr=%h exc=%b want 00000310 0",
               ok ? gnt_q[1] : 32'h0, misalign_exc);
    end
`else
    wait_gnts(2, ok);
    tests++;
    if (!ok || gnt_q[1] !== 32'h0000_2004 || misalign_exc !== 1'b0) begin
      fails++;
      $display("FAIL jalr_addr: addr=%h exc=%b want 00002004 0",
               ok ? gnt_q[1] : 32'h0, misalign_exc);
    end
`endif
  endtask

  task automatic test_redirect_out();
    bit ok;
    do_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 2;
    inst_ready = 1'b0;
    wait_valid(ok);
    @(posedge cpu_clk);
    #1;
    redir_valid = 1'b1;
    redir_op = 2'd1;
    redir_pc = 32'h0000_0040;
    redir_imm = 32'h0000_0080;
    inst_ready = 1'b1;
    @(negedge cpu_clk);
    tests++;
    if (inst_valid !== 1'b0) begin
      fails++;
      $display("FAIL out_mask: v=%b want 0", inst_valid);
    end
    @(posedge cpu_clk);
    #1;
    redir_valid = 1'b0;
    inst_ready = 1'b0;
    wait_gnts(2, ok);
    tests++;
    if (!ok || gnt_q[1] !== 32'h0000_00C0 || acc_pc_q.size() != 0) begin
      fails++;
      $display("FAIL out_redir: addr=%h accepted=%0d want 000000c0 0",
               ok ? gnt_q[1] : 32'h0, acc_pc_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    gnt_pct = 100; lat_min = 5; lat_max = 5;
    inst_ready = 1'b1;
    wait_gnts(1, ok);
    @(posedge cpu_clk);
    #1;
    cpu_rst_n = 1'b0;
    @(posedge cpu_clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge cpu_clk);
      tests++;
      if ({imem_req, inst_valid, misalign_exc, inst, inst_pc} !== '0) begin
        fails++;
        $display("FAIL mid_reset_%0d: req=%b v=%b inst=%h pc=%h want 0",
                 i, imem_req, inst_valid, inst, inst_pc);
      end
    end
    @(posedge cpu_clk);
    #1;
    cpu_rst_n = 1'b1;
    clear_logs();
    lat_min = 1; lat_max = 2;
    wait_acc(1, ok);
    tests++;
    if (!ok || gnt_q[0] !== RST_PC || acc_pc_q[0] !== RST_PC
        || acc_in_q[0] !== mem_word(RST_PC)) begin
      fails++;
      $display("FAIL mid_reset_refetch: ok=%b gnt=%h pc=%h want %h",
               ok, ok ? gnt_q[0] : 32'h0, ok ? acc_pc_q[0] : 32'h0, RST_PC);
    end
    inst_ready = 1'b0;
  endtask

  task automatic test_random_redirect();
    logic [31:0] exp_pc;
    int n;
    int k;
    do_reset();
    gnt_pct = int'($urandom_range(100, 50));
    lat_min = 1; lat_max = 3;
    exp_pc = RST_PC;
    n = 0;
    for (int c = 0; c < 4000 && n < 60; c++) begin
      @(posedge cpu_clk);
      #1;
      inst_ready = ($urandom_range(3) != 0);
      redir_valid = ($urandom_range(7) == 0);
      redir_op = 2'($urandom_range(3));
      redir_pc = $urandom & 32'hFFFF_FFFC;
      redir_rs1 = $urandom & 32'hFFFF_FFFC;
      k = int'($urandom_range(511)) - 256;
      redir_imm = 32'(k * 4);
      @(negedge cpu_clk);
      if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
        tests++;
        if (inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin
          fails++;
          $display("FAIL rand_redir_%0d: pc=%h inst=%h want %h %h",
                   n, inst_pc, inst, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        n++;
      end
      if (redir_valid) begin
        exp_pc = exp_target(redir_op, redir_pc, redir_rs1, redir_imm);
      end
    end
    @(posedge cpu_clk);
    #1;
    redir_valid = 1'b0;
    inst_ready = 1'b0;
    tests++;
    if (n < 60) begin
      fails++;
      $display("FAIL rand_redir_count: got %0d want 60", n);
    end
  endtask

  initial begin
    cpu_rst_n = 1'b0;
    inst_ready = 1'b0;
    redir_valid = 1'b0;
    redir_op = 2'd0;
    redir_pc = '0;
    redir_rs1 = '0;
    redir_imm = '0;
    test_reset();
    test_stall();
    test_sequential();
    test_redirect_wait();
    test_jalr();
    test_redirect_out();
    test_reset_mid();
    test_random_redirect();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
